// File: rtl/pll_stream_reset_seq_if.sv
// Signal bundle between the stream PLL reset sequencer and its surroundings:
// PLL lock/reset, software request, stream reset and status.
interface pll_stream_reset_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pll_locked;
  logic             sw_reset_req;
  logic             pll_rst;
  logic             stream_reset_n;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] retry_count;
  logic [CNT_W-1:0] lock_loss_count;

  modport master (
    input  pll_locked, sw_reset_req,
    output pll_rst, stream_reset_n, ready, state, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked, sw_reset_req,
    input  pll_rst, stream_reset_n, ready, state, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_stream_reset_seq.sv
// Stream PLL reset sequencer on the 50 MHz reference clock: pulses the PLL reset,
// qualifies lock, then releases stream reset. PLL_STREAM_RESET_SEQ_STATUS_EN builds the status counters.
module pll_stream_reset_seq #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned HOLD_CYCLES  = 64,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pll_stream_reset_seq_if.master bus
);
  localparam logic [1:0] PLL_RST   = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam int unsigned CYC_M1  = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int unsigned CYC_MAX = (CYC_M1 > LOCK_TIMEOUT) ? CYC_M1 : LOCK_TIMEOUT;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [1:0]             state_q, state_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d, cyc_inc;
  logic [STB_W-1:0]       stb_q, stb_d, stb_inc;
  logic                   pll_rst_q, run_q;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign cyc_inc  = cyc_q + CYC_W'(1);
  assign stb_inc  = stb_q + STB_W'(1);

  // Shared cycle counter restarts on every state entry; stable counter lives only in WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_inc;
    stb_d   = '0;
    if (bus.sw_reset_req) begin
      state_d = PLL_RST;
      cyc_d   = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cyc_inc == CYC_W'(RST_CYCLES)) begin
            state_d = WAIT_LOCK;
            cyc_d   = '0;
          end
        end
        WAIT_LOCK: begin
          stb_d = locked_s ? stb_inc : '0;
          // Lock acceptance beats a coincident timeout.
          if (locked_s && stb_inc == STB_W'(LOCK_STABLE)) begin
            state_d = HOLD;
            cyc_d   = '0;
            stb_d   = '0;
          end else if (cyc_inc == CYC_W'(LOCK_TIMEOUT)) begin
            state_d = PLL_RST;
            cyc_d   = '0;
            stb_d   = '0;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cyc_d   = '0;
          end else if (cyc_inc == CYC_W'(HOLD_CYCLES)) begin
            state_d = RUN;
            cyc_d   = '0;
          end
        end
        RUN: begin
          cyc_d = '0;
          if (!locked_s) state_d = PLL_RST;
        end
        default: begin
          state_d = PLL_RST;
          cyc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      state_q   <= PLL_RST;
      cyc_q     <= '0;
      stb_q     <= '0;
      pll_rst_q <= 1'b1;
      run_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      // Outputs registered from the next state so they switch with the state itself.
      pll_rst_q <= (state_d == PLL_RST);
      run_q     <= (state_d == RUN);
    end
  end

  assign bus.state          = state_q;
  assign bus.pll_rst        = pll_rst_q;
  assign bus.stream_reset_n = run_q;
  assign bus.ready          = run_q;

`ifdef PLL_STREAM_RESET_SEQ_STATUS_EN
  logic [CNT_W-1:0] retry_q, loss_q;
  logic             retry_hit, loss_hit;

  // A software request into PLL_RST is never counted.
  assign retry_hit = !bus.sw_reset_req && state_q == WAIT_LOCK && state_d == PLL_RST;
  assign loss_hit  = !bus.sw_reset_req && state_q == RUN && state_d == PLL_RST;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_hit && retry_q != '1) retry_q <= retry_q + CNT_W'(1);
      if (loss_hit && loss_q != '1) loss_q <= loss_q + CNT_W'(1);
    end
  end

  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = loss_q;
`else
  assign bus.retry_count     = {CNT_W{1'b0}};
  assign bus.lock_loss_count = {CNT_W{1'b0}};
`endif
endmodule
